// File: rtl/add_sub_pipe.sv
// Pipelined N-bit add/subtract with carry/borrow, signed overflow flags and optional saturation.
// Latency STAGES cycles; the whole pipe stalls as one unit when the result is held off (in_ready = !out_valid || out_ready).
module add_sub_pipe #(
  parameter int N      = 32,
  parameter int STAGES = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         cin,
  input  logic         op,
  input  logic         sat,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] result,
  output logic         cout,
  output logic         ovf,
  output logic         zero,
  output logic         neg,
  output logic         ovf_sticky,
  input  logic         clr_sticky
);

  typedef struct packed {
    logic [N-1:0] res;
    logic         cout;
    logic         ovf;
    logic         zero;
    logic         neg;
  } res_t;

  logic [N-1:0] b_eff;
  logic         c_eff;
  logic [N:0]   sum;
  logic [N-1:0] raw;
  logic [N-1:0] sat_val;
  logic [N-1:0] res_c;
  logic         ovf_c;
  res_t         new_dat;

  logic              adv;
  logic [STAGES-1:0] vld_q, vld_d;
  res_t              dat_q [STAGES];
  res_t              dat_d [STAGES];
  logic              ovf_sticky_q, ovf_sticky_d;

  // Subtract is a + ~b + ~cin, so cout doubles as "no borrow".
  always_comb begin
    b_eff   = op ? b : ~b;
    c_eff   = op ? cin : ~cin;
    sum     = {1'b0, a} + {1'b0, b_eff} + {{N{1'b0}}, c_eff};
    raw     = sum[N-1:0];
    ovf_c   = (a[N-1] == b_eff[N-1]) && (raw[N-1] != a[N-1]);
    sat_val = a[N-1] ? {1'b1, {(N-1){1'b0}}} : {1'b0, {(N-1){1'b1}}};
    res_c   = (sat && ovf_c) ? sat_val : raw;
    new_dat      = '0;
    new_dat.res  = res_c;
    new_dat.cout = sum[N];
    new_dat.ovf  = ovf_c;
    new_dat.zero = (res_c == '0);
    new_dat.neg  = res_c[N-1];
  end

  assign adv      = !vld_q[STAGES-1] || out_ready;
  assign in_ready = adv;

  // Bubbles are shifted along with real ops so stage spacing is preserved.
  always_comb begin
    vld_d = vld_q;
    dat_d = dat_q;
    if (adv) begin
      vld_d[0] = in_valid;
      dat_d[0] = new_dat;
      for (int i = 1; i < STAGES; i++) begin
        vld_d[i] = vld_q[i-1];
        dat_d[i] = dat_q[i-1];
      end
    end
  end

  always_comb begin
    ovf_sticky_d = ovf_sticky_q;
    if (clr_sticky) ovf_sticky_d = 1'b0;
    if (vld_q[STAGES-1] && out_ready && dat_q[STAGES-1].ovf) ovf_sticky_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q        <= '0;
      ovf_sticky_q <= 1'b0;
      for (int i = 0; i < STAGES; i++) dat_q[i] <= '0;
    end else begin
      vld_q        <= vld_d;
      ovf_sticky_q <= ovf_sticky_d;
      dat_q        <= dat_d;
    end
  end

  assign out_valid  = vld_q[STAGES-1];
  assign result     = dat_q[STAGES-1].res;
  assign cout       = dat_q[STAGES-1].cout;
  assign ovf        = dat_q[STAGES-1].ovf;
  assign zero       = dat_q[STAGES-1].zero;
  assign neg        = dat_q[STAGES-1].neg;
  assign ovf_sticky = ovf_sticky_q;

endmodule

// File: tb/tb_add_sub_pipe.sv
// Bench for add_sub_pipe: directed corner ops plus random traffic against an integer-arithmetic model.
module tb_add_sub_pipe;
  localparam int N      = 32;
  localparam int STAGES = 2;
  localparam longint MAXS = 64'sd2147483647;
  localparam longint MINS = -64'sd2147483648;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid, in_ready;
  logic [N-1:0] a, b;
  logic         cin, op, sat;
  logic         out_valid, out_ready;
  logic [N-1:0] result;
  logic         cout, ovf, zero, neg, ovf_sticky, clr_sticky;

  add_sub_pipe #(.N(N), .STAGES(STAGES)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin), .op(op), .sat(sat),
    .out_valid(out_valid), .out_ready(out_ready), .result(result),
    .cout(cout), .ovf(ovf), .zero(zero), .neg(neg),
    .ovf_sticky(ovf_sticky), .clr_sticky(clr_sticky)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [N-1:0] res;
    logic         cout, ovf, zero, neg;
    int           acc_cyc;
  } exp_t;

  exp_t         q[$];
  logic         m_sticky;
  int           cyc, last_stall;
  int           checks, errors;
  logic         s_ov, s_ir, s_acc, s_cout, s_ovf, s_zero, s_neg, s_sticky;
  logic [N-1:0] s_result;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Exact integer arithmetic: signed range decides overflow, unsigned compare decides carry/borrow.
  function automatic exp_t model(input logic [N-1:0] ma, mb, input logic mcin, mop, msat);
    exp_t        m;
    longint      sa, sb, ex;
    logic [63:0] ua, ub;
    sa = longint'($signed(ma));
    sb = longint'($signed(mb));
    ua = {32'b0, ma};
    ub = {32'b0, mb};
    ex = mop ? sa + sb + longint'(mcin) : sa - sb - longint'(mcin);
    m.ovf  = (ex > MAXS) || (ex < MINS);
    m.cout = mop ? ((ua + ub + {63'b0, mcin}) > 64'hFFFF_FFFF) : (ua >= ub + {63'b0, mcin});
    if (msat && m.ovf) m.res = (ex > 0) ? 32'h7FFF_FFFF : 32'h8000_0000;
    else               m.res = ex[N-1:0];
    m.zero    = (m.res == 0);
    m.neg     = m.res[N-1];
    m.acc_cyc = 0;
    return m;
  endfunction

  function automatic logic [N-1:0] pick();
    case ($urandom_range(0, 7))
      0:       return 32'h0;
      1:       return 32'h1;
      2:       return 32'h7FFF_FFFF;
      3:       return 32'h8000_0000;
      4:       return 32'hFFFF_FFFF;
      default: return $urandom();
    endcase
  endfunction

  task automatic cycle(input logic iv, input logic [N-1:0] ia, ib, input logic icin, iop, isat,
                       input logic ordy, input logic iclr);
    exp_t e;
    logic xfer, xovf;
    @(negedge clk);
    in_valid = iv; a = ia; b = ib; cin = icin; op = iop; sat = isat;
    out_ready = ordy; clr_sticky = iclr;
    #1;
    cyc++;
    chk("sticky", ovf_sticky, m_sticky);
    chk("in_ready", in_ready, !out_valid || ordy);
    s_ov = out_valid; s_ir = in_ready; s_result = result; s_cout = cout;
    s_ovf = ovf; s_zero = zero; s_neg = neg; s_sticky = ovf_sticky;
    s_acc = iv && in_ready;
    xfer  = out_valid && ordy;
    xovf  = 1'b0;
    if (out_valid) begin
      if (q.size() == 0) begin
        chk("phantom out_valid", out_valid, 0);
      end else begin
        e = q[0];
        chk("result", result, e.res);
        chk("cout", cout, e.cout);
        chk("ovf", ovf, e.ovf);
        chk("zero", zero, e.zero);
        chk("neg", neg, e.neg);
        if (xfer) begin
          if (last_stall < e.acc_cyc) chk("latency", cyc - e.acc_cyc, STAGES);
          xovf = e.ovf;
          void'(q.pop_front());
        end
      end
    end
    if (!ordy) last_stall = cyc;
    if (xfer && xovf) m_sticky = 1'b1;
    else if (iclr)    m_sticky = 1'b0;
    if (s_acc) begin
      e = model(ia, ib, icin, iop, isat);
      e.acc_cyc = cyc;
      q.push_back(e);
    end
  endtask

  task automatic idle(input logic ordy, input logic iclr);
    cycle(1'b0, '0, '0, 1'b0, 1'b0, 1'b0, ordy, iclr);
  endtask

  // One op with out_ready high; the last idle cycle samples the op on the output.
  task automatic dir_op(input logic [N-1:0] ia, ib, input logic icin, iop, isat, input logic clr_last);
    cycle(1'b1, ia, ib, icin, iop, isat, 1'b1, 1'b0);
    repeat (STAGES - 1) idle(1'b1, 1'b0);
    idle(1'b1, clr_last);
    chk("dir out_valid", s_ov, 1);
  endtask

  logic [N-1:0] opa [3];
  logic [N-1:0] opb [3];
  int           idx;

  initial begin
    checks = 0; errors = 0; cyc = 0; last_stall = 0; m_sticky = 1'b0;
    rst_n = 1'b0; in_valid = 0; a = '0; b = '0; cin = 0; op = 0; sat = 0;
    out_ready = 1'b1; clr_sticky = 1'b0;
    #12;
    chk("rst out_valid", out_valid, 0);
    chk("rst in_ready", in_ready, 1);
    chk("rst result", result, 0);
    chk("rst flags", {cout, ovf, zero, neg, ovf_sticky}, 0);
    @(negedge clk);
    rst_n = 1'b1;

    dir_op(32'd75, 32'd25, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("add75+25 res", s_result, 100);
    chk("add75+25 cout", s_cout, 0);
    chk("add75+25 ovf", s_ovf, 0);
    chk("add75+25 zero", s_zero, 0);

    dir_op(32'd75, 32'd25, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("sub75-25 res", s_result, 50);
    chk("sub75-25 cout", s_cout, 1);
    dir_op(32'd25, 32'd75, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("sub25-75 res", s_result, 32'hFFFF_FFCE);
    chk("sub25-75 cout", s_cout, 0);
    chk("sub25-75 neg", s_neg, 1);

    dir_op(32'h7FFF_FFFF, 32'd1, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("addovf res", s_result, 32'h8000_0000);
    chk("addovf ovf", s_ovf, 1);
    chk("addovf neg", s_neg, 1);
    idle(1'b1, 1'b0);
    chk("addovf sticky", s_sticky, 1);
    dir_op(32'h7FFF_FFFF, 32'd1, 1'b0, 1'b1, 1'b1, 1'b0);
    chk("addsat res", s_result, 32'h7FFF_FFFF);
    chk("addsat ovf", s_ovf, 1);

    dir_op(32'h8000_0000, 32'd1, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("subsat res", s_result, 32'h8000_0000);
    chk("subsat ovf", s_ovf, 1);
    dir_op(32'd5, 32'd5, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("sub5-5 res", s_result, 0);
    chk("sub5-5 zero", s_zero, 1);
    chk("sub5-5 cout", s_cout, 1);
    dir_op(32'd10, 32'd3, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("sub borrow-in res", s_result, 6);

    // Three ops back to back while the consumer stalls for three cycles.
    opa[0] = 32'd1000; opb[0] = 32'd1;
    opa[1] = 32'd2000; opb[1] = 32'd2;
    opa[2] = 32'd3000; opb[2] = 32'd3;
    idx = 0;
    for (int c = 0; c < 20; c++) begin
      cycle(idx < 3, (idx < 3) ? opa[idx] : 32'h0, (idx < 3) ? opb[idx] : 32'h0,
            1'b0, 1'b1, 1'b0, !(c >= 1 && c <= 3), 1'b0);
      if (c == 2 || c == 3) begin
        chk("stall in_ready", s_ir, 0);
        chk("stall held result", s_result, 32'd1001);
      end
      if (s_acc) idx++;
      if (idx == 3 && q.size() == 0) break;
    end
    chk("stall all accepted", idx, 3);
    chk("stall drained", q.size(), 0);

    // Clear coincident with an overflow transfer: the set must win.
    idle(1'b1, 1'b1);
    idle(1'b1, 1'b0);
    chk("sticky cleared", s_sticky, 0);
    dir_op(32'h7FFF_FFFF, 32'd1, 1'b0, 1'b1, 1'b0, 1'b1);
    idle(1'b1, 1'b0);
    chk("sticky set wins", s_sticky, 1);

    // Reset with two ops in flight.
    cycle(1'b1, 32'd10, 32'd20, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 32'd30, 32'd40, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    in_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst out_valid", out_valid, 0);
    chk("midrst in_ready", in_ready, 1);
    chk("midrst result", result, 0);
    chk("midrst sticky", ovf_sticky, 0);
    q.delete();
    m_sticky = 1'b0;
    last_stall = cyc;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    idle(1'b0, 1'b0);
    chk("post-rst in_ready", s_ir, 1);
    for (int i = 0; i < 5; i++) begin
      idle(1'b1, 1'b0);
      chk("post-rst no stale", s_ov, 0);
    end

    for (int i = 0; i < 2000; i++) begin
      cycle($urandom_range(0, 3) != 0, pick(), pick(), 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            $urandom_range(0, 3) != 0, $urandom_range(0, 15) == 0);
    end
    for (int i = 0; i < 20 && q.size() > 0; i++) idle(1'b1, 1'b0);
    chk("final drain", q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

endmodule

// File: doc/add_sub_pipe.md
ADD_SUB_PIPE -- requirements
Module: add_sub_pipe

Interface
REQ-001 Parameter N, default 32: operand/result width in bits; legal N >= 4.
REQ-002 Parameter STAGES, default 2: pipeline depth in register stages; legal 1..4.
REQ-003 clk  input  1  rising-edge clock; the block's only clock.
REQ-004 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 in_valid  input  1  operation presented on a, b, cin, op, sat.
REQ-006 in_ready  output  1  block accepts the operation this cycle.
REQ-007 a, b  input  N each  operands, two's complement for flag purposes.
REQ-008 cin  input  1  carry-in (add) / borrow-in (sub).
REQ-009 op  input  1  1 = add, 0 = subtract.
REQ-010 sat  input  1  1 = signed saturation on overflow.
REQ-011 out_valid  output  1  result fields valid.
REQ-012 out_ready  input  1  consumer accepts the result.
REQ-013 result  output  N  sum/difference, possibly saturated.
REQ-014 cout  output  1  raw carry out of N-bit adder.
REQ-015 ovf, zero, neg  output  1 each  signed overflow; result == 0; result[N-1].
REQ-016 ovf_sticky  output  1  set by any transferred overflow result.
REQ-017 clr_sticky  input  1  synchronous clear of ovf_sticky.

Function
REQ-018 Accept = in_valid && in_ready; transfer = out_valid && out_ready.
REQ-019 Pipeline advances as a unit when adv = !out_valid || out_ready; in_ready SHALL equal adv, combinationally.
REQ-020 On adv, every stage SHALL capture its predecessor, bubbles included; with adv low all stages, including output fields, hold stable.
REQ-021 With out_ready held high, an op accepted at edge k SHALL present out_valid at edge k+STAGES-1; throughput one op per cycle.
REQ-022 Results SHALL emerge in acceptance order; none dropped or duplicated under any in_valid/out_ready pattern.
REQ-023 Add: {cout, raw} = a + b + cin, computed in N+1 bits.
REQ-024 Sub: b' = ~b, {cout, raw} = a + b' + ~cin, i.e. a - b - cin; cout = 1 means no borrow.
REQ-025 ovf = (a[N-1] == b'[N-1]) && (raw[N-1] != a[N-1]); b' = b for add.
REQ-026 sat = 0 or ovf = 0: result = raw.
REQ-027 sat = 1 and ovf = 1: result = {0, all 1} when a[N-1] = 0, else {1, all 0}.
REQ-028 zero and neg SHALL reflect the final (possibly saturated) result; cout and ovf are always the unsaturated values.
REQ-029 ovf_sticky SHALL set at the edge of a transfer with ovf = 1.
REQ-030 clr_sticky = 1 SHALL clear ovf_sticky at the next edge unless the same-edge set of REQ-029 occurs; set wins.
REQ-031 Operand and mode inputs SHALL be sampled only on accept; changes while in_ready = 0 have no effect.
REQ-032 Adder structure and register placement across stages are free; only the timing of REQ-021 is normative.

Reset
REQ-033 rst_n low SHALL immediately clear all stage valid bits, out_valid and ovf_sticky; result, cout, ovf, zero, neg SHALL read 0.
REQ-034 Reset mid-operation SHALL discard all in-flight ops; no stale result appears after rst_n rises.
REQ-035 in_ready SHALL be 1 during reset and in the first cycle after release (out_valid = 0).

Verification (N = 32, STAGES = 2)
REQ-036 add 75 + 25, cin = 0, out_ready = 1 -> next cycle result = 100, cout = 0, ovf = 0, zero = 0.
REQ-037 sub 75 - 25, cin = 0 -> result = 50, cout = 1; sub 25 - 75 -> result = 0xFFFFFFCE, cout = 0, neg = 1.
REQ-038 add 0x7FFFFFFF + 1, sat = 0 -> result = 0x80000000, ovf = 1, neg = 1, ovf_sticky = 1 after transfer; same with sat = 1 -> result = 0x7FFFFFFF, ovf = 1.
REQ-039 sub 0x80000000 - 1, sat = 1 -> 0x80000000, ovf = 1; sub 5 - 5, cin = 0 -> result = 0, zero = 1, cout = 1.
REQ-040 Three back-to-back ops, out_ready low 3 cycles -> in_ready = 0, result held stable; release gives results in order, no loss.
REQ-041 rst_n pulsed low with two ops in flight -> out_valid = 0 at once, no result after release; also clr_sticky coincident with an overflow transfer -> ovf_sticky = 1.
